// File: rtl/core_run_ctrl.sv
// ============================================================================
// core_run_ctrl : core reset sequencing, breakpoint/EBREAK/timeout halt control
// Rev 1.0
// ============================================================================
`default_nettype none

module core_run_ctrl #(
  parameter int XLEN       = 32,
  parameter int NUM_BP     = 4,
  parameter int RST_CYCLES = 2,
  parameter int TO_W       = 16,
  parameter int DRAIN_W    = 4,
  localparam int c_idx_w   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_req_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [31:0]            inst_i,
  input  logic [NUM_BP*XLEN-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]      bp_en_i,
  input  logic [DRAIN_W-1:0]     drain_i,
  input  logic [TO_W-1:0]        timeout_i,
  output logic                   core_nrst_o,
  output logic                   running_o,
  output logic                   halted_o,
  output logic                   stop_o,
  output logic [1:0]             halt_cause_o,
  output logic [c_idx_w-1:0]     hit_idx_o,
  output logic [31:0]            cycle_cnt_o
);

  localparam logic [31:0]   c_ebreak   = 32'h0010_0073;
  localparam int            c_rc_w     = $clog2(RST_CYCLES + 1);
  localparam logic [c_rc_w-1:0] c_rst_init = c_rc_w'(RST_CYCLES - 1);
  localparam int            c_cmp_w    = ((TO_W > 32) ? TO_W : 32) + 1;

  localparam logic [1:0] c_cause_none = 2'd0;
  localparam logic [1:0] c_cause_bp   = 2'd1;
  localparam logic [1:0] c_cause_ebrk = 2'd2;
  localparam logic [1:0] c_cause_to   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [c_rc_w-1:0]    rst_cnt_q, rst_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [31:0]          cycle_cnt_q, cycle_cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [c_idx_w-1:0]   hit_idx_q, hit_idx_d;
  logic                 core_nrst_q, core_nrst_d;
  logic                 running_q, running_d;
  logic                 halted_q, halted_d;
  logic                 stop_q, stop_d;

  logic                 w_bp_hit;
  logic [c_idx_w-1:0]   w_bp_idx;
  logic                 w_ebreak;
  logic                 w_to_hit;
  logic [31:0]          w_cnt_inc;
  logic [c_cmp_w-1:0]   w_cnt_p1;
  logic [c_cmp_w-1:0]   w_to_ext;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    w_bp_hit = 1'b0;
    w_bp_idx = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (bp_en_i[k] && (pc_i == bp_addr_i[k*XLEN +: XLEN])) begin
        w_bp_hit = 1'b1;
        w_bp_idx = c_idx_w'(k);
      end
    end
  end

  // While in RUN, cycle_cnt equals the number of RUN cycles already completed.
  assign w_cnt_p1  = {{(c_cmp_w-32){1'b0}}, cycle_cnt_q} + {{(c_cmp_w-1){1'b0}}, 1'b1};
  assign w_to_ext  = {{(c_cmp_w-TO_W){1'b0}}, timeout_i};
  assign w_to_hit  = (timeout_i != '0) && (w_cnt_p1 == w_to_ext);
  assign w_ebreak  = (inst_i == c_ebreak);
  assign w_cnt_inc = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    cause_d     = cause_q;
    hit_idx_d   = hit_idx_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (run_req_i) begin
          state_d     = S_RESET;
          rst_cnt_d   = c_rst_init;
          cycle_cnt_d = '0;
          cause_d     = c_cause_none;
          hit_idx_d   = '0;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        cycle_cnt_d = w_cnt_inc;
        if (w_bp_hit || w_ebreak) begin
          cause_d     = w_bp_hit ? c_cause_bp : c_cause_ebrk;
          hit_idx_d   = w_bp_hit ? w_bp_idx : hit_idx_q;
          drain_cnt_d = drain_i;
          state_d     = (drain_i == '0) ? S_HALT : S_DRAIN;
        end else if (w_to_hit) begin
          cause_d = c_cause_to;
          state_d = S_HALT;
        end
      end
      S_DRAIN: begin
        cycle_cnt_d = w_cnt_inc;
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q <= {{(DRAIN_W-1){1'b0}}, 1'b1}) begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_nrst_d = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_HALT);
    running_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    halted_d    = (state_d == S_HALT);
    stop_d      = (state_d == S_HALT) && (state_q != S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      cause_q     <= c_cause_none;
      hit_idx_q   <= '0;
      core_nrst_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      cause_q     <= cause_d;
      hit_idx_q   <= hit_idx_d;
      core_nrst_q <= core_nrst_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      stop_q      <= stop_d;
    end
  end

  assign core_nrst_o  = core_nrst_q;
  assign running_o    = running_q;
  assign halted_o     = halted_q;
  assign stop_o       = stop_q;
  assign halt_cause_o = cause_q;
  assign hit_idx_o    = hit_idx_q;
  assign cycle_cnt_o  = cycle_cnt_q;

endmodule

`default_nettype wire

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Synthesisable run-control and watchdog block for the RISC-V core.
- Sequences the core's active-low reset (core_nrst_o).
- Monitors the retiring PC against NUM_BP programmable breakpoints, detects EBREAK, and enforces a cycle timeout.
- Halts after a programmable drain delay and reports the halt cause.
- Sits beside the core in the SoC top and in FPGA/emulation builds, replacing fixed-PC/fixed-delay stop logic with a parametrised, reusable controller.

Parameters:
XLEN, 32, width of PC and breakpoint addresses
NUM_BP, 4, number of PC breakpoint comparators (1..16)
RST_CYCLES, 2, cycles core_nrst_o is held low after a run request (>=1)
TO_W, 16, width of timeout_i
DRAIN_W, 4, width of drain_i

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
run_req_i  in  1  start/restart pulse, honoured in IDLE and HALT only
pc_i  in  XLEN  core current PC
inst_i  in  32  core current instruction
bp_addr_i  in  NUM_BP*XLEN  breakpoint addresses, entry k at [k*XLEN +: XLEN]
bp_en_i  in  NUM_BP  per-breakpoint enable
drain_i  in  DRAIN_W  cycles to keep running after a breakpoint/EBREAK match
timeout_i  in  TO_W  max RUN cycles; 0 disables the timeout
core_nrst_o  out  1  active-low reset to core
running_o  out  1  high in RUN and DRAIN
halted_o  out  1  high in HALT
stop_o  out  1  one-cycle pulse on entry to HALT
halt_cause_o  out  2  0 none, 1 breakpoint, 2 EBREAK, 3 timeout
hit_idx_o  out  max(1,$clog2(NUM_BP))  index of the breakpoint that matched
cycle_cnt_o  out  32  RUN+DRAIN cycle count

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; core_nrst_o=0; running_o=0; halted_o=0; stop_o=0; halt_cause_o=0; hit_idx_o=0; cycle_cnt_o=0.
  - Internal counters are cleared.
  - rst asserted in any state (mid-run, mid-drain) aborts immediately to these values.
- FSM states: IDLE, RESET, RUN, DRAIN, HALT.
  - IDLE: core_nrst_o=0. run_req_i -> RESET.
  - RESET: core_nrst_o=0 for exactly RST_CYCLES cycles, then -> RUN. On entry: cycle_cnt_o, halt_cause_o and hit_idx_o are cleared. run_req_i is ignored.
  - RUN: core_nrst_o=1; cycle_cnt_o increments each cycle, saturating at 32'hFFFF_FFFF.
    - bp_hit = OR over k of (bp_en_i[k] && pc_i==bp_addr_k).
    - ebreak = (inst_i==32'h0010_0073).
    - to_hit = (timeout_i!=0) && (RUN-cycle count + 1 == timeout_i), i.e. fires on the timeout_i-th RUN cycle.
  - Priority when several events occur in the same cycle: bp_hit > ebreak > to_hit.
    - bp_hit: lowest matching index is latched into hit_idx_o; cause=1.
    - ebreak: cause=2.
    - to_hit: cause=3, -> HALT directly (no drain).
  - For bp_hit/ebreak: drain_i==0 -> HALT; else -> DRAIN with drain_cnt=drain_i (drain_i sampled once, at the match edge).
  - DRAIN: core keeps running and cycle_cnt_o keeps incrementing. drain_cnt decrements each cycle; at the edge where drain_cnt==1 -> HALT. Breakpoints, EBREAK and timeout are ignored in DRAIN; the latched cause and index are kept.
  - HALT: core_nrst_o=1, core clock not gated (the core is held only by the integrator using halted_o). All outputs stable. run_req_i -> RESET.
- Halt latency: match sampled at edge E0 -> halted_o=1 after edge E0+drain_i (drain_i=0: after E0).
- stop_o: high for exactly the first cycle of HALT.
- running_o/halted_o: registered state decodes, no glitches.
- bp_addr_i/bp_en_i may change at any time; they are compared combinationally each RUN cycle.
- Restart from HALT re-runs the reset sequence; there is no resume-without-reset.

Test Plan:
- Reset seq: rst 1->0, run_req_i pulse at cycle 3 -> core_nrst_o low through cycle 5 (RST_CYCLES=2), high from cycle 6; running_o=1; cycle_cnt_o=1 after first RUN edge.
- Breakpoint with drain: bp_en_i=4'b0100, bp_addr[2]=32'h328, drain_i=7, pc_i hits 32'h328 at edge E0 -> halted_o and stop_o rise after E0+7; halt_cause_o=1, hit_idx_o=2; stop_o low the following cycle.
- Simultaneous events: bp[1] and bp[3] both match, inst_i=32'h00100073, and the timeout fires, all in one cycle; drain_i=0 -> HALT next edge, cause=1, hit_idx_o=1.
- Timeout: timeout_i=16'd265, no matches -> HALT entered on the 265th RUN edge, cause=3, cycle_cnt_o=265; with timeout_i=0 the block never halts in 1000 cycles.
- EBREAK: inst_i=32'h00100073, drain_i=0 -> halt next edge, cause=2; a new bp match during a drain_i=5 drain does not change the cause.
- Async reset mid-DRAIN: rst pulses while drain_cnt=3 -> immediately IDLE, core_nrst_o=0, halt_cause_o=0, cycle_cnt_o=0; a later run_req_i performs the full sequence.
